rf_wb_arbiter: RTL

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/looper_pkg.sv | 27 ++
 rtl/rr_pick2.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/looper_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// looper_pkg : shared widths, source codes and buffer entry type
// Revision   : 1.0
// ---------------------------------------------------------------------------
package looper_pkg;

  localparam int PREG_W   = 6;
  localparam int DATA_W   = 16;
  localparam int AL_IDX_W = 6;
  localparam int NUM_SRC  = 4;
  localparam int NUM_WP   = 2;

  localparam int SRC_ALU1 = 0;
  localparam int SRC_ALU2 = 1;
  localparam int SRC_MULT = 2;
  localparam int SRC_LD   = 3;

  typedef struct packed {
    logic                vld;
    logic [PREG_W-1:0]   pnum;
    logic [DATA_W-1:0]   data;
    logic [AL_IDX_W-1:0] idx;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick2 : combinational round-robin picker returning up to two winners
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_pick2 #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt0,
  output logic [N-1:0]         gnt1,
  output logic                 gvld0,
  output logic                 gvld1
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] w_idx;

  // Scan from ptr with natural wrap (N is a power of two)
  always_comb begin
    gnt0  = '0;
    gnt1  = '0;
    gvld0 = 1'b0;
    gvld1 = 1'b0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = ptr + PTR_W'(k);
      if (req[w_idx]) begin
        if (!gvld0) begin
          gnt0[w_idx] = 1'b1;
          gvld0       = 1'b1;
        end else if (!gvld1) begin
          gnt1[w_idx] = 1'b1;
          gvld1       = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_wb_arbiter : buffers one result per source and writes up to two per
//                 cycle to the register file in round-robin order
// Revision      : 1.0
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int NUM_SRC = looper_pkg::NUM_SRC,
  parameter int NUM_WP  = looper_pkg::NUM_WP
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0]                   src_vld,
  input  logic [NUM_SRC*looper_pkg::PREG_W-1:0]   src_pnum,
  input  logic [NUM_SRC*looper_pkg::DATA_W-1:0]   src_data,
  input  logic [NUM_SRC*looper_pkg::AL_IDX_W-1:0] src_idx,
  output logic [NUM_SRC-1:0]                   src_rdy,
  input  logic                                 mis_pred,
  output logic [NUM_WP-1:0]                    wrt_vld,
  output logic [NUM_WP*looper_pkg::PREG_W-1:0]    wrt_pnum,
  output logic [NUM_WP*looper_pkg::DATA_W-1:0]    wrt_data,
  output logic [NUM_WP*looper_pkg::AL_IDX_W-1:0]  done_idx
);

  import looper_pkg::*;

  localparam int PTR_W = $clog2(NUM_SRC);

  wb_entry_t          r_buf [NUM_SRC];
  logic [PTR_W-1:0]   r_rr_ptr;

  logic [NUM_SRC-1:0] w_buf_vld;
  logic [NUM_SRC-1:0] w_gnt0;
  logic [NUM_SRC-1:0] w_gnt1;
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_accept;
  logic               w_gvld0;
  logic               w_gvld1;
  wb_entry_t          w_win0;
  wb_entry_t          w_win1;
  logic [PTR_W-1:0]   w_last_idx;

  always_comb begin
    w_buf_vld = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_buf_vld[i] = r_buf[i].vld;
    end
  end

  rr_pick2 #(
    .N (NUM_SRC)
  ) u_pick (
    .req   (w_buf_vld),
    .ptr   (r_rr_ptr),
    .gnt0  (w_gnt0),
    .gnt1  (w_gnt1),
    .gvld0 (w_gvld0),
    .gvld1 (w_gvld1)
  );

  assign w_grant  = w_gnt0 | w_gnt1;
  // A granted buffer drains at the same edge, so its source may refill it
  assign src_rdy  = (~w_buf_vld | w_grant) & {NUM_SRC{~mis_pred}};
  assign w_accept = src_vld & src_rdy;

  always_comb begin
    w_win0     = '0;
    w_win1     = '0;
    w_last_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt0[i]) w_win0 = r_buf[i];
      if (w_gnt1[i]) w_win1 = r_buf[i];
      if (w_gvld1 ? w_gnt1[i] : w_gnt0[i]) w_last_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_buf[i] <= '0;
      end
      r_rr_ptr <= '0;
      wrt_vld  <= '0;
      wrt_pnum <= '0;
      wrt_data <= '0;
      done_idx <= '0;
    end else if (mis_pred) begin
      // Every buffered result is younger than the flush point
      for (int i = 0; i < NUM_SRC; i++) begin
        r_buf[i].vld <= 1'b0;
      end
      r_rr_ptr <= '0;
      wrt_vld  <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_accept[i]) begin
          r_buf[i].vld  <= 1'b1;
          r_buf[i].pnum <= src_pnum[i*PREG_W +: PREG_W];
          r_buf[i].data <= src_data[i*DATA_W +: DATA_W];
          r_buf[i].idx  <= src_idx[i*AL_IDX_W +: AL_IDX_W];
        end else if (w_grant[i]) begin
          r_buf[i].vld <= 1'b0;
        end
      end
      wrt_vld  <= {w_gvld1, w_gvld0};
      wrt_pnum <= {w_win1.pnum, w_win0.pnum};
      wrt_data <= {w_win1.data, w_win0.data};
      done_idx <= {w_win1.idx, w_win0.idx};
      if (w_gvld0 | w_gvld1) begin
        r_rr_ptr <= w_last_idx + PTR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
